// File: rtl/mul9_pp_source.sv
// Partial-product source for the 9x9 unsigned multiplier compressor tree.
// Operand pairs are expanded into a column-packed AND array and queued in a small FIFO.
module mul9_pp_source #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8:0]       in_a,
    input  logic [8:0]       in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [80:0]      pp_bus,
    output logic [CNT_W-1:0] issued,
    output logic [CNT_W-1:0] retired,
    input  logic             flush
);

    localparam int PW = $clog2(DEPTH);

    // Column c holds a[j]&b[c-j] for j = max(0,c-8) upward, heights 1..9..1.
    function automatic logic [80:0] pack_pp(input logic [8:0] a, input logic [8:0] b);
        logic [80:0] pp;
        int unsigned off;
        int unsigned h;
        int unsigned j0;
        pp  = '0;
        off = 0;
        for (int unsigned c = 0; c < 17; c++) begin
            h  = (c <= 8) ? c + 1 : 17 - c;
            j0 = (c > 8) ? c - 8 : 0;
            for (int unsigned k = 0; k < 9; k++) begin
                if (k < h) begin
                    pp[7'(off + k)] = a[4'(j0 + k)] & b[4'(c - j0 - k)];
                end
            end
            off += h;
        end
        return pp;
    endfunction

    logic [80:0] mem [DEPTH];
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;

    always_comb begin
        empty     = (wr_ptr == rd_ptr);
        full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
        in_ready  = !flush && (!full || out_ready);
        out_valid = !flush && !empty;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        pp_bus    = empty ? '0 : mem[rd_ptr[PW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PW-1:0]] <= pack_pp(in_a, in_b);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            issued  <= '0;
            retired <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (PW+1)'(1);
                issued <= issued + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + (PW+1)'(1);
                retired <= retired + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mul9_pp_source.sv
// Directed and random checks of mul9_pp_source packing, handshake, flush, counters and reset.
module tb_mul9_pp_source;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, flush;
    logic [8:0]  in_a, in_b;
    logic [80:0] pp_bus;
    logic [15:0] issued, retired;

    logic        v4, rdy4, ov4, ordy4, fl4;
    logic [8:0]  a4, b4;
    logic [80:0] pp4;
    logic [3:0]  iss4, ret4;

    int total = 0;
    int bad   = 0;
    int exp_iss = 0;
    int exp_ret = 0;
    int discards = 0;

    always #5 clk = ~clk;

    mul9_pp_source #(.DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .pp_bus(pp_bus), .issued(issued), .retired(retired), .flush(flush));

    mul9_pp_source #(.DEPTH(2), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4),
        .in_a(a4), .in_b(b4), .out_valid(ov4), .out_ready(ordy4),
        .pp_bus(pp4), .issued(iss4), .retired(ret4), .flush(fl4));

    // Compressor-tree reference: weight every column bit by 2^column and sum.
    function automatic logic [17:0] reduce_bus(input logic [80:0] bus);
        logic [17:0] s;
        int unsigned off;
        int unsigned h;
        s = '0;
        off = 0;
        for (int unsigned c = 0; c < 17; c++) begin
            h = (c <= 8) ? c + 1 : 17 - c;
            for (int unsigned k = 0; k < h; k++) s += 18'(bus[off + k]) << c;
            off += h;
        end
        return s;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 0; out_ready = 0; flush = 0; in_a = '0; in_b = '0;
        v4 = 0; ordy4 = 0; fl4 = 0; a4 = '0; b4 = '0;
        repeat (2) @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (pp_bus !== 81'd0) begin bad++; $display("FAIL reset_pp_bus got=%h want=0", pp_bus); end
        total++; if (issued !== 16'd0 || retired !== 16'd0) begin bad++; $display("FAIL reset_counters got=%0d/%0d want=0/0", issued, retired); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One accept with out_ready=1; checks the head at the next negedge, then lets it pop.
    task automatic push_pop_check(input logic [8:0] a, input logic [8:0] b, input logic [80:0] want, input string nm);
        in_a = a; in_b = b; in_valid = 1; out_ready = 1;
        @(negedge clk);
        in_valid = 0; exp_iss++;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL %s_valid got=%b want=1", nm, out_valid); end
        total++; if (pp_bus !== want) begin bad++; $display("FAIL %s_bus got=%h want=%h", nm, pp_bus, want); end
        total++; if (issued !== 16'(exp_iss)) begin bad++; $display("FAIL %s_issued got=%0d want=%0d", nm, issued, exp_iss); end
        @(negedge clk);
        exp_ret++;
        total++; if (retired !== 16'(exp_ret) || out_valid !== 1'b0) begin bad++; $display("FAIL %s_retired got=%0d/%b want=%0d/0", nm, retired, out_valid, exp_ret); end
    endtask

    task automatic test_all_ones();
        push_pop_check(9'h1FF, 9'h1FF, {81{1'b1}}, "all_ones");
    endtask

    task automatic test_single_bits();
        push_pop_check(9'h001, 9'h100, 81'd1 << 36, "a0b8");
        push_pop_check(9'h100, 9'h100, 81'd1 << 80, "a8b8");
        push_pop_check(9'h001, 9'h002, 81'd1 << 1,  "a0b1");
        push_pop_check(9'h002, 9'h001, 81'd1 << 2,  "a1b0");
        push_pop_check(9'h001, 9'h001, 81'd1,       "a0b0");
    endtask

    task automatic test_random_products();
        logic [17:0] prev;
        logic [8:0]  ra, rb;
        out_ready = 1;
        prev = '0;
        for (int i = 0; i <= 1000; i++) begin
            if (i > 0) begin
                total++; if (out_valid !== 1'b1 || reduce_bus(pp_bus) !== prev) begin
                    bad++; $display("FAIL rand_product[%0d] got=%0d/%b want=%0d/1", i, reduce_bus(pp_bus), out_valid, prev);
                end
            end
            if (i < 1000) begin
                ra = 9'($urandom); rb = 9'($urandom);
                in_a = ra; in_b = rb; in_valid = 1;
                #1;
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rand_in_ready[%0d] got=%b want=1", i, in_ready); end
                prev = 18'(ra) * 18'(rb);
                @(negedge clk);
            end
        end
        in_valid = 0;
        @(negedge clk);
        exp_iss += 1000; exp_ret += 1000;
        total++; if (out_valid !== 1'b0 || issued !== 16'(exp_iss) || retired !== 16'(exp_ret)) begin
            bad++; $display("FAIL rand_drain got=%b/%0d/%0d want=0/%0d/%0d", out_valid, issued, retired, exp_iss, exp_ret);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 0;
        in_a = 9'h001; in_b = 9'h001; in_valid = 1;
        @(negedge clk);
        in_a = 9'h100; in_b = 9'h100;
        @(negedge clk);
        in_a = 9'h001; in_b = 9'h100;
        exp_iss += 2;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b want=0", in_ready); end
        total++; if (pp_bus !== 81'd1) begin bad++; $display("FAIL bp_head got=%h want=%h", pp_bus, 81'd1); end
        @(negedge clk);
        total++; if (pp_bus !== 81'd1 || issued !== 16'(exp_iss)) begin bad++; $display("FAIL bp_hold got=%h/%0d want=%h/%0d", pp_bus, issued, 81'd1, exp_iss); end
        out_ready = 1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_pop_frees got=%b want=1", in_ready); end
        @(negedge clk);
        in_valid = 0; exp_iss++; exp_ret++;
        total++; if (pp_bus !== (81'd1 << 80) || issued !== 16'(exp_iss)) begin bad++; $display("FAIL bp_order2 got=%h/%0d want=%h/%0d", pp_bus, issued, 81'd1 << 80, exp_iss); end
        @(negedge clk);
        exp_ret++;
        total++; if (pp_bus !== (81'd1 << 36)) begin bad++; $display("FAIL bp_order3 got=%h want=%h", pp_bus, 81'd1 << 36); end
        @(negedge clk);
        exp_ret++;
        total++; if (out_valid !== 1'b0 || retired !== 16'(exp_ret)) begin bad++; $display("FAIL bp_drain got=%b/%0d want=0/%0d", out_valid, retired, exp_ret); end
    endtask

    task automatic test_flush();
        out_ready = 0;
        in_a = 9'h1FF; in_b = 9'h1FF; in_valid = 1;
        repeat (2) @(negedge clk);
        exp_iss += 2;
        flush = 1;
        #1;
        total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_gate got=%b/%b want=0/0", in_ready, out_valid); end
        @(negedge clk);
        flush = 0; in_valid = 0; discards += 2;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_empty got=%b want=0", out_valid); end
        total++; if (issued !== 16'(exp_iss) || retired !== 16'(exp_ret)) begin bad++; $display("FAIL flush_counters got=%0d/%0d want=%0d/%0d", issued, retired, exp_iss, exp_ret); end
        total++; if (16'(issued - retired) !== 16'(discards)) begin bad++; $display("FAIL flush_invariant got=%0d want=%0d", 16'(issued - retired), discards); end
        push_pop_check(9'h002, 9'h001, 81'd1 << 2, "post_flush");
    endtask

    task automatic test_counter_wrap();
        a4 = 9'h003; b4 = 9'h003; ordy4 = 1; v4 = 1;
        repeat (17) @(negedge clk);
        v4 = 0;
        @(negedge clk);
        total++; if (iss4 !== 4'd1 || ret4 !== 4'd1) begin bad++; $display("FAIL wrap_counters got=%0d/%0d want=1/1", iss4, ret4); end
        total++; if (ov4 !== 1'b0) begin bad++; $display("FAIL wrap_empty got=%b want=0", ov4); end
    endtask

    task automatic test_async_reset();
        out_ready = 0;
        in_a = 9'h055; in_b = 9'h0AA; in_valid = 1;
        repeat (2) @(negedge clk);
        in_valid = 0;
        #1;
        total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL arst_prefull got=%b/%b want=0/1", in_ready, out_valid); end
        #1 rst_n = 0;
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL arst_handshake got=%b/%b want=0/1", out_valid, in_ready); end
        total++; if (issued !== 16'd0 || retired !== 16'd0 || pp_bus !== 81'd0) begin bad++; $display("FAIL arst_state got=%0d/%0d/%h want=0/0/0", issued, retired, pp_bus); end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_single_bits();
        test_random_products();
        test_backpressure();
        test_flush();
        test_counter_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
